// File: rtl/ste_minmax_hold.sv
// ste_minmax_hold: running min/max/count tracker with display hold and sticky limit flags, all outputs registered
module ste_minmax_hold #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din_i,
  input  logic              din_update_i,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic              hold_i,
  input  logic [DATA_W-1:0] lim_hi_i,
  input  logic [DATA_W-1:0] lim_lo_i,
  output logic [DATA_W-1:0] cur_o,
  output logic [DATA_W-1:0] min_o,
  output logic [DATA_W-1:0] max_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              valid_o,
  output logic              over_o,
  output logic              under_o,
  output logic              hold_o,
  output logic              dout_update_o
);
  typedef enum logic [1:0] {IDLE, EMPTY, TRACK, HOLD} state_t;
  state_t state, state_nx;
  logic acc;
  always_comb begin
    state_nx = state;
    acc = 1'b0;
    if (clr_i) state_nx = en_i ? EMPTY : IDLE;
    else if (!en_i) state_nx = IDLE;
    else if (state == IDLE) state_nx = valid_o ? TRACK : EMPTY;
    else if (state == HOLD) state_nx = hold_i ? HOLD : (valid_o ? TRACK : EMPTY);
    else if (hold_i) state_nx = HOLD;
    else if (din_update_i) begin
      acc = 1'b1;
      state_nx = TRACK;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      state <= rst ? IDLE : state_nx;
      cur_o <= '0;
      min_o <= '1;
      max_o <= '0;
      cnt_o <= '0;
      valid_o <= 1'b0;
      over_o <= 1'b0;
      under_o <= 1'b0;
      hold_o <= 1'b0;
      dout_update_o <= 1'b0;
    end else begin
      state <= state_nx;
      hold_o <= state_nx == HOLD;
      dout_update_o <= acc;
      if (acc) begin
        cur_o <= din_i;
        cnt_o <= cnt_o + {{(CNT_W-1){1'b0}}, ~&cnt_o};
        min_o <= (state == EMPTY || din_i < min_o) ? din_i : min_o;
        max_o <= (state == EMPTY || din_i > max_o) ? din_i : max_o;
        valid_o <= 1'b1;
        over_o <= over_o | (din_i > lim_hi_i);
        under_o <= under_o | (din_i < lim_lo_i);
      end
    end
  end
endmodule

// File: tb/tb_ste_minmax_hold.sv
// tb_ste_minmax_hold: directed self-checking bench for ste_minmax_hold
module tb_ste_minmax_hold;
  logic clk = 0, rst = 1, upd = 0, en = 0, clr = 0, hold = 0;
  logic [15:0] din = 0, lim_hi = 16'hffff, lim_lo = 0;
  logic [15:0] cur, mn, mx, cnt;
  logic valid, over, under, hold_q, dup;
  logic [15:0] cur4, mn4, mx4;
  logic [3:0] cnt4;
  logic valid4, over4, under4, hold4, dup4;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  ste_minmax_hold dut (
    .clk(clk), .rst(rst), .din_i(din), .din_update_i(upd), .en_i(en), .clr_i(clr),
    .hold_i(hold), .lim_hi_i(lim_hi), .lim_lo_i(lim_lo), .cur_o(cur), .min_o(mn),
    .max_o(mx), .cnt_o(cnt), .valid_o(valid), .over_o(over), .under_o(under),
    .hold_o(hold_q), .dout_update_o(dup)
  );

  ste_minmax_hold #(.DATA_W(16), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .din_i(din), .din_update_i(upd), .en_i(en), .clr_i(clr),
    .hold_i(hold), .lim_hi_i(lim_hi), .lim_lo_i(lim_lo), .cur_o(cur4), .min_o(mn4),
    .max_o(mx4), .cnt_o(cnt4), .valid_o(valid4), .over_o(over4), .under_o(under4),
    .hold_o(hold4), .dout_update_o(dup4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic u, input logic [15:0] d);
    upd = u;
    din = d;
    @(posedge clk);
    #1;
    upd = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " cur"}, cur, 0);
    chk({tag, " min"}, mn, 16'hffff);
    chk({tag, " max"}, mx, 0);
    chk({tag, " cnt"}, cnt, 0);
    chk({tag, " flags"}, {valid, over, under, hold_q, dup}, 0);
  endtask

  initial begin
    step(0, 0);
    step(0, 0);
    rst = 0;
    chk_reset("rst");
    // test 1: basic tracking, 1-cycle latency, back-to-back strobes
    en = 1;
    step(0, 0);
    step(1, 100);
    chk("t1 dup1", dup, 1);
    chk("t1 cur1", cur, 100);
    step(1, 50);
    chk("t1 dup2", dup, 1);
    step(1, 300);
    chk("t1 dup3", dup, 1);
    chk("t1 vals", {cur, mn, mx, cnt}, {16'd300, 16'd50, 16'd300, 16'd3});
    chk("t1 valid", valid, 1);
    chk("t1 flags", {over, under}, 0);
    step(0, 0);
    chk("t1 dup off", dup, 0);
    // test 2: sticky limit flags, then clear
    clr = 1;
    step(0, 0);
    clr = 0;
    chk_reset("t2 clr0");
    lim_hi = 200;
    lim_lo = 60;
    step(1, 100);
    chk("t2 f100", {over, under}, 2'b00);
    step(1, 250);
    chk("t2 f250", {over, under}, 2'b10);
    step(1, 40);
    chk("t2 f40", {over, under}, 2'b11);
    chk("t2 min", mn, 40);
    step(1, 100);
    chk("t2 f100b", {over, under}, 2'b11);
    clr = 1;
    step(0, 0);
    clr = 0;
    chk_reset("t2 clr");
    // test 3: hold freezes outputs and drops samples
    step(1, 100);
    chk("t3 empty first", {mn, mx}, {16'd100, 16'd100});
    step(1, 200);
    hold = 1;
    step(0, 0);
    chk("t3 hold_o", hold_q, 1);
    step(1, 500);
    chk("t3 dup in hold", dup, 0);
    step(0, 0);
    step(1, 10);
    chk("t3 dup in hold2", dup, 0);
    step(0, 0);
    chk("t3 frozen", {cur, mn, mx, cnt}, {16'd200, 16'd100, 16'd200, 16'd2});
    chk("t3 hold_o2", hold_q, 1);
    hold = 0;
    step(0, 0);
    chk("t3 release", {hold_q, dup}, 0);
    step(1, 500);
    chk("t3 after", {mx, cnt, 15'd0, dup}, {16'd500, 16'd3, 15'd0, 1'b1});
    chk("t3 over", over, 1);
    // test 4: same-cycle clear/hold with strobe
    lim_hi = 16'hffff;
    lim_lo = 0;
    clr = 1;
    step(1, 77);
    clr = 0;
    chk("t4 clr drop", {cnt, valid, dup}, 0);
    chk("t4 clr cur", cur, 0);
    step(1, 77);
    chk("t4 accept", {cur, cnt}, {16'd77, 16'd1});
    hold = 1;
    step(1, 88);
    chk("t4 hold drop", {cur, cnt, dup, hold_q}, {16'd77, 16'd1, 1'b0, 1'b1});
    hold = 0;
    step(0, 0);
    // test 5: saturating counter (CNT_W=4 instance)
    clr = 1;
    step(0, 0);
    clr = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, i == 10 ? 16'd5 : (i == 15 ? 16'd900 : 16'(100 + i)));
      chk($sformatf("t5 cnt4 %0d", i), cnt4, i < 15 ? i + 1 : 15);
    end
    chk("t5 cnt16", cnt, 20);
    chk("t5 minmax4", {mn4, mx4}, {16'd5, 16'd900});
    chk("t5 cur4", cur4, 119);
    // test 6: mid-operation reset, enable gating
    clr = 1;
    step(0, 0);
    clr = 0;
    step(1, 10);
    step(1, 20);
    step(1, 30);
    rst = 1;
    step(1, 40);
    rst = 0;
    chk_reset("t6 rst");
    step(0, 0);
    step(1, 70);
    step(1, 30);
    chk("t6 track", {cnt, mn, mx}, {16'd2, 16'd30, 16'd70});
    en = 0;
    step(1, 5);
    chk("t6 ignored", {cur, cnt, mn, 15'd0, dup}, {16'd30, 16'd2, 16'd30, 16'd0});
    en = 1;
    step(0, 0);
    step(1, 90);
    chk("t6 resume", {cur, cnt, mn, mx}, {16'd90, 16'd3, 16'd30, 16'd90});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
